// File: rtl/boot_seq_loader_if.sv
// Boot copier bus: ROM read side and core-memory download side.
interface boot_seq_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dn_go;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [DATA_W-1:0] dn_data;
    logic              dn_wait;

    modport master (
        output rd_addr,
        input  rd_data,
        output dn_go,
        output dn_wr,
        output dn_addr,
        output dn_data,
        input  dn_wait
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  dn_go,
        input  dn_wr,
        input  dn_addr,
        input  dn_data,
        output dn_wait
    );
endinterface

// File: rtl/boot_seq_loader.sv
// Post-reset boot loader: copies a run-time sized block from boot ROM into
// core memory over the download port, then pulses execute_enable.
module boot_seq_loader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 16,
    parameter int ROM_LAT    = 1,
    parameter int AUTO_START = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] exec_addr,
    output logic [ADDR_W-1:0] execute_addr,
    output logic              execute_enable,
    boot_seq_loader_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    // Last value of the ROM wait counter; rd_data is captured on that edge.
    localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [DATA_W-1:0] dn_data_q, dn_data_d;
    logic              dn_wr_q, dn_wr_d;
    logic              dn_go_q, dn_go_d;
    logic [ADDR_W-1:0] exec_q, exec_d;
    logic              exec_en_q, exec_en_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [2:0]        lat_q, lat_d;
    logic              auto_q, auto_d;
    logic              go;

    // Auto-start request only survives the first edge after reset release.
    assign go = (start | auto_q) & ~abort;

    // Next-state and datapath updates for the copy sequencer.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        dn_wr_d   = dn_wr_q;
        dn_go_d   = dn_go_q;
        exec_d    = exec_q;
        exec_en_d = 1'b0;
        remain_d  = remain_q;
        lat_d     = lat_q;
        auto_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    rd_addr_d = src_base;
                    dn_addr_d = dst_base;
                    exec_d    = exec_addr;
                    remain_d  = len;
                    lat_d     = 3'd0;
                    dn_go_d   = 1'b1;
                    state_d   = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    dn_go_d = 1'b0;
                    state_d = IDLE;
                end else if (lat_q == LAT_LAST) begin
                    dn_data_d = bus.rd_data;
                    dn_wr_d   = 1'b1;
                    state_d   = WRITE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            WRITE: begin
                // A write accepted on an abort edge has already reached the sink.
                if (abort) begin
                    dn_wr_d = 1'b0;
                    dn_go_d = 1'b0;
                    state_d = IDLE;
                end else if (!bus.dn_wait) begin
                    dn_wr_d  = 1'b0;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        dn_go_d   = 1'b0;
                        exec_en_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        dn_addr_d = dn_addr_q + ADDR_W'(1);
                        lat_d     = 3'd0;
                        state_d   = FETCH;
                    end
                end
            end
            default: begin
                // dn_go still high means a zero-length copy that has not pulsed yet.
                dn_go_d   = 1'b0;
                exec_en_d = dn_go_q;
                state_d   = dn_go_q ? DONE : IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and re-arms auto-start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
            dn_wr_q   <= 1'b0;
            dn_go_q   <= 1'b0;
            exec_q    <= '0;
            exec_en_q <= 1'b0;
            remain_q  <= '0;
            lat_q     <= 3'd0;
            auto_q    <= (AUTO_START != 0);
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            dn_wr_q   <= dn_wr_d;
            dn_go_q   <= dn_go_d;
            exec_q    <= exec_d;
            exec_en_q <= exec_en_d;
            remain_q  <= remain_d;
            lat_q     <= lat_d;
            auto_q    <= auto_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.dn_go       = dn_go_q;
    assign bus.dn_wr       = dn_wr_q;
    assign bus.dn_addr     = dn_addr_q;
    assign bus.dn_data     = dn_data_q;
    assign execute_addr    = exec_q;
    assign execute_enable  = exec_en_q;

endmodule

// File: tb/tb_boot_seq_loader.sv
// Directed bench for boot_seq_loader: one instance with a combinational ROM
// and manual start, one with a registered ROM and auto-start.
module tb_boot_seq_loader;

    typedef struct {
        logic [15:0]        src, dst, ln, ex;
        int                 n;
        logic [0:3][15:0]   waddr;
        logic [0:3][7:0]    wdata;
        logic [0:3][7:0]    wcyc;
        int                 done;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] c;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int a_exec_n = 0;
    int b_exec_n = 0;

    logic        a_rst, a_start, a_abort, a_exec;
    logic [15:0] a_src, a_dst, a_len, a_ex, a_eaddr;
    logic        b_rst, b_start, b_abort, b_exec;
    logic [15:0] b_src, b_dst, b_len, b_ex, b_eaddr;
    logic [15:0] b_raddr;

    wr_t a_q[$];
    wr_t b_q[$];
    vec_t tbl[3];

    boot_seq_loader_if #(.ADDR_W(16), .DATA_W(8)) a_if();
    boot_seq_loader_if #(.ADDR_W(16), .DATA_W(8)) b_if();

    boot_seq_loader #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .ROM_LAT(1), .AUTO_START(0)) u_a (
        .clk_sys(clk), .reset(a_rst), .start(a_start), .abort(a_abort),
        .src_base(a_src), .dst_base(a_dst), .len(a_len), .exec_addr(a_ex),
        .execute_addr(a_eaddr), .execute_enable(a_exec), .bus(a_if));

    boot_seq_loader #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .ROM_LAT(2), .AUTO_START(1)) u_b (
        .clk_sys(clk), .reset(b_rst), .start(b_start), .abort(b_abort),
        .src_base(b_src), .dst_base(b_dst), .len(b_len), .exec_addr(b_ex),
        .execute_addr(b_eaddr), .execute_enable(b_exec), .bus(b_if));

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        return a[7:0] + 8'h10 + a[15:8];
    endfunction

    // ROM contents: combinational for A, registered address for B.
    assign a_if.rd_data = rom_f(a_if.rd_addr);
    always @(posedge clk) b_raddr <= b_if.rd_addr;
    assign b_if.rd_data = rom_f(b_raddr);
    assign b_if.dn_wait = 1'b0;

    // Edge counter plus logs of accepted writes and execute pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!a_rst && a_if.dn_wr && !a_if.dn_wait)
            a_q.push_back('{a: a_if.dn_addr, d: a_if.dn_data, c: 32'(cyc + 1)});
        if (!b_rst && b_if.dn_wr && !b_if.dn_wait)
            b_q.push_back('{a: b_if.dn_addr, d: b_if.dn_data, c: 32'(cyc + 1)});
        if (a_exec) a_exec_n <= a_exec_n + 1;
        if (b_exec) b_exec_n <= b_exec_n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start_a(output int s);
        a_start = 1'b1;
        tick(1);
        s = cyc;
        a_start = 1'b0;
    endtask

    task automatic wait_exec(input bit sel_b, input int budget, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            tick(1);
            if (sel_b ? b_exec : a_exec) begin
                at = cyc;
                seen = 1'b1;
            end
        end
    endtask

    task automatic run_copy(input vec_t v);
        int s, at, n0;
        a_q.delete();
        n0 = a_exec_n;
        a_src = v.src; a_dst = v.dst; a_len = v.ln; a_ex = v.ex;
        pulse_start_a(s);
        chk("go_after_start", 32'(a_if.dn_go), 32'd1);
        wait_exec(1'b0, 200, at);
        chk("done_cycle", 32'(at - s), 32'(v.done));
        chk("go_low_at_done", 32'(a_if.dn_go), 32'd0);
        chk("execute_addr", 32'(a_eaddr), 32'(v.ex));
        tick(1);
        chk("exec_one_cycle", 32'(a_exec), 32'd0);
        tick(1);
        chk("exec_pulses", 32'(a_exec_n - n0), 32'd1);
        chk("n_writes", 32'(a_q.size()), 32'(v.n));
        for (int i = 0; i < v.n; i++) begin
            if (i < a_q.size()) begin
                chk("wr_addr", 32'(a_q[i].a), 32'(v.waddr[i]));
                chk("wr_data", 32'(a_q[i].d), 32'(v.wdata[i]));
                chk("wr_cycle", a_q[i].c - 32'(s), 32'(v.wcyc[i]));
            end
        end
    endtask

    initial begin
        int s, at, n0;
        tbl[0] = '{src: 16'h0000, dst: 16'h0000, ln: 16'd4, ex: 16'h1234, n: 4,
                   waddr: {16'h0000, 16'h0001, 16'h0002, 16'h0003},
                   wdata: {8'h10, 8'h11, 8'h12, 8'h13},
                   wcyc:  {8'd2, 8'd4, 8'd6, 8'd8}, done: 8};
        tbl[1] = '{src: 16'hFFFE, dst: 16'hFFFF, ln: 16'd3, ex: 16'hABCD, n: 3,
                   waddr: {16'hFFFF, 16'h0000, 16'h0001, 16'h0000},
                   wdata: {8'h0D, 8'h0E, 8'h10, 8'h00},
                   wcyc:  {8'd2, 8'd4, 8'd6, 8'd0}, done: 6};
        tbl[2] = '{src: 16'h0005, dst: 16'h0300, ln: 16'd1, ex: 16'h00FF, n: 1,
                   waddr: {16'h0300, 16'h0000, 16'h0000, 16'h0000},
                   wdata: {8'h15, 8'h00, 8'h00, 8'h00},
                   wcyc:  {8'd2, 8'd0, 8'd0, 8'd0}, done: 2};

        a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_if.dn_wait = 1'b0;
        a_src = 16'h0; a_dst = 16'h0; a_len = 16'h0; a_ex = 16'h0;
        b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0;
        b_src = 16'h0100; b_dst = 16'h8000; b_len = 16'd3; b_ex = 16'h0000;
        tick(3);

        // Reset state.
        chk("rst_rd_addr", 32'(a_if.rd_addr), 32'd0);
        chk("rst_dn_go", 32'(a_if.dn_go), 32'd0);
        chk("rst_dn_wr", 32'(a_if.dn_wr), 32'd0);
        chk("rst_dn_addr", 32'(a_if.dn_addr), 32'd0);
        chk("rst_dn_data", 32'(a_if.dn_data), 32'd0);
        chk("rst_exec", 32'({a_eaddr, 7'd0, a_exec}), 32'd0);
        chk("rst_b_go", 32'(b_if.dn_go), 32'd0);
        a_rst = 1'b0;
        tick(3);
        chk("no_autostart_a", 32'(a_if.dn_go), 32'd0);

        for (int i = 0; i < 3; i++) run_copy(tbl[i]);

        // Five stall edges on the second byte of a 3-byte copy.
        a_q.delete(); n0 = a_exec_n;
        a_src = 16'h0040; a_dst = 16'h0200; a_len = 16'd3; a_ex = 16'h0777;
        pulse_start_a(s);
        tick(3);
        a_if.dn_wait = 1'b1;
        chk("stall_presented", 32'(a_if.dn_wr), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("stall_wr", 32'(a_if.dn_wr), 32'd1);
            chk("stall_addr", 32'(a_if.dn_addr), 32'h0201);
            chk("stall_data", 32'(a_if.dn_data), 32'h51);
        end
        a_if.dn_wait = 1'b0;
        wait_exec(1'b0, 100, at);
        chk("stall_done", 32'(at - s), 32'd11);
        tick(2);
        chk("stall_pulses", 32'(a_exec_n - n0), 32'd1);
        chk("stall_nwr", 32'(a_q.size()), 32'd3);
        if (a_q.size() == 3) begin
            chk("stall_w0", {8'h0, a_q[0].a, a_q[0].d}, 32'h0002_0050);
            chk("stall_w1", {8'h0, a_q[1].a, a_q[1].d}, 32'h0002_0151);
            chk("stall_w2", {8'h0, a_q[2].a, a_q[2].d}, 32'h0002_0252);
            chk("stall_c1", a_q[1].c - 32'(s), 32'd9);
            chk("stall_c2", a_q[2].c - 32'(s), 32'd11);
        end

        // Zero-length copy.
        a_q.delete();
        a_len = 16'd0; a_ex = 16'h4321;
        pulse_start_a(s);
        chk("len0_go", 32'(a_if.dn_go), 32'd1);
        chk("len0_exec_early", 32'(a_exec), 32'd0);
        tick(1);
        chk("len0_exec", 32'(a_exec), 32'd1);
        chk("len0_go_low", 32'(a_if.dn_go), 32'd0);
        chk("len0_eaddr", 32'(a_eaddr), 32'h4321);
        tick(1);
        chk("len0_exec_off", 32'(a_exec), 32'd0);
        tick(2);
        chk("len0_nwr", 32'(a_q.size()), 32'd0);

        // start and abort together in IDLE: no copy.
        a_q.delete(); n0 = a_exec_n;
        a_len = 16'd2; a_start = 1'b1; a_abort = 1'b1;
        tick(1);
        a_start = 1'b0; a_abort = 1'b0;
        chk("sa_go", 32'(a_if.dn_go), 32'd0);
        tick(4);
        chk("sa_nwr", 32'(a_q.size()), 32'd0);
        chk("sa_pulses", 32'(a_exec_n - n0), 32'd0);

        // start while busy is ignored.
        a_q.delete(); n0 = a_exec_n;
        a_src = 16'h0000; a_dst = 16'h0600; a_len = 16'd2; a_ex = 16'h0AAA;
        pulse_start_a(s);
        a_src = 16'h0030; a_dst = 16'h0900; a_len = 16'd1; a_ex = 16'h0BBB;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_exec(1'b0, 100, at);
        chk("busy_done", 32'(at - s), 32'd4);
        chk("busy_eaddr", 32'(a_eaddr), 32'h0AAA);
        tick(2);
        chk("busy_pulses", 32'(a_exec_n - n0), 32'd1);
        chk("busy_nwr", 32'(a_q.size()), 32'd2);
        if (a_q.size() == 2)
            chk("busy_w1", {8'h0, a_q[1].a, a_q[1].d}, 32'h0006_0111);

        // Abort in FETCH after the first byte.
        a_q.delete(); n0 = a_exec_n;
        a_src = 16'h0000; a_dst = 16'h0500; a_len = 16'd4; a_ex = 16'h0CCC;
        pulse_start_a(s);
        tick(2);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        chk("abort_go", 32'(a_if.dn_go), 32'd0);
        chk("abort_wr", 32'(a_if.dn_wr), 32'd0);
        tick(4);
        chk("abort_pulses", 32'(a_exec_n - n0), 32'd0);
        chk("abort_nwr", 32'(a_q.size()), 32'd1);

        // Abort on the same edge a write is accepted: that write counts.
        a_q.delete(); n0 = a_exec_n;
        a_dst = 16'h0700; a_len = 16'd3;
        pulse_start_a(s);
        tick(1);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        chk("abortw_go", 32'(a_if.dn_go), 32'd0);
        chk("abortw_wr", 32'(a_if.dn_wr), 32'd0);
        tick(3);
        chk("abortw_nwr", 32'(a_q.size()), 32'd1);
        chk("abortw_pulses", 32'(a_exec_n - n0), 32'd0);

        // Reset asserted while a write is pending.
        a_q.delete(); n0 = a_exec_n;
        a_src = 16'h0020; a_dst = 16'h0C00; a_len = 16'd4; a_ex = 16'h5555;
        pulse_start_a(s);
        tick(1);
        chk("mid_wr_before", 32'(a_if.dn_wr), 32'd1);
        a_rst = 1'b1;
        #1;
        chk("mid_rst_wr_go", 32'({a_if.dn_wr, a_if.dn_go}), 32'd0);
        chk("mid_rst_addr", 32'({a_if.rd_addr, a_if.dn_addr}), 32'd0);
        chk("mid_rst_data", 32'({a_if.dn_data, a_eaddr}), 32'd0);
        tick(2);
        a_rst = 1'b0;
        tick(4);
        chk("mid_rst_pulses", 32'(a_exec_n - n0), 32'd0);
        chk("mid_rst_nwr", 32'(a_q.size()), 32'd0);
        run_copy(tbl[0]);

        // Registered ROM with auto-start on reset release.
        b_q.delete();
        b_rst = 1'b0;
        chk("b_idle_before", 32'(b_if.dn_go), 32'd0);
        tick(1);
        s = cyc;
        chk("b_auto_go", 32'(b_if.dn_go), 32'd1);
        chk("b_auto_rd", 32'(b_if.rd_addr), 32'h0100);
        wait_exec(1'b1, 100, at);
        chk("b_done", 32'(at - s), 32'd9);
        chk("b_go_low", 32'(b_if.dn_go), 32'd0);
        chk("b_eaddr", 32'(b_eaddr), 32'h0000);
        tick(2);
        chk("b_nwr", 32'(b_q.size()), 32'd3);
        if (b_q.size() == 3) begin
            chk("b_w0", {8'h0, b_q[0].a, b_q[0].d}, 32'h0080_0011);
            chk("b_w1", {8'h0, b_q[1].a, b_q[1].d}, 32'h0080_0112);
            chk("b_w2", {8'h0, b_q[2].a, b_q[2].d}, 32'h0080_0213);
            chk("b_c0", b_q[0].c - 32'(s), 32'd3);
            chk("b_c1", b_q[1].c - 32'(s), 32'd6);
            chk("b_c2", b_q[2].c - 32'(s), 32'd9);
        end

        // Auto-start fires again after a second reset (zero length).
        b_rst = 1'b1; b_len = 16'd0; b_ex = 16'h2468;
        tick(2);
        b_rst = 1'b0;
        tick(2);
        chk("b_reauto_exec", 32'(b_exec), 32'd1);
        chk("b_reauto_eaddr", 32'(b_eaddr), 32'h2468);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_seq_loader.md
Name: boot_seq_loader

Overview:
- Parametrised successor to the top-level post-reset boot-ROM copier.
- Copies a programmable-length block from a read-only source (boot ROM) into core memory through the dn_* download port, then pulses execute_enable with a start address.
- Adds over the fixed copier: run-time source/destination/length, configurable ROM read latency, a dn_wait back-pressure handshake, abort, and optional auto-start.
- Sits between the boot ROM and pcw_core in the emu top level.

Parameters:
ADDR_W, 16, width of source/destination/execute addresses
DATA_W, 8, data width
LEN_W, 16, width of length input
ROM_LAT, 1, rising edges from rd_addr change to rd_data valid (1 = combinational ROM, 2 = registered-address block RAM); legal 1..4
AUTO_START, 1, 1 = start a copy on the first clock after reset release, using the port values at that time

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  cancel copy; return to IDLE, no execute pulse
src_base  in  ADDR_W  first ROM address; latched at start
dst_base  in  ADDR_W  first destination address; latched at start
len  in  LEN_W  byte count; latched at start
exec_addr  in  ADDR_W  start address; latched at start
rd_addr  out  ADDR_W  ROM read address
rd_data  in  DATA_W  ROM read data
dn_go  out  1  high while a copy is in progress
dn_wr  out  1  write strobe
dn_addr  out  ADDR_W  write address
dn_data  out  DATA_W  write data
dn_wait  in  1  sink stall; write not accepted while high
execute_addr  out  ADDR_W  latched exec_addr
execute_enable  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async): all outputs 0; state IDLE; counters 0. Reset asserted mid-copy ends the copy immediately with no execute pulse. AUTO_START fires again after every reset release.
- State IDLE: on start, or on the first edge after reset release when AUTO_START=1, latch src_base/dst_base/len/exec_addr. Set rd_addr=src_base, dn_addr=dst_base, execute_addr=exec_addr, dn_go=1.
  - len=0: go to DONE.
  - len>0: go to FETCH.
- State FETCH: hold rd_addr for ROM_LAT edges. On the ROM_LAT-th edge, capture rd_data into dn_data, set dn_wr=1, go to WRITE.
- State WRITE: dn_wr, dn_addr and dn_data stay stable while dn_wait=1.
  - A write is accepted at an edge where dn_wr=1 and dn_wait=0. On acceptance: dn_wr=0, decrement remaining count.
  - Count becomes 0: go to DONE.
  - Count not 0: increment rd_addr and dn_addr, go to FETCH.
- State DONE: on entry edge, dn_go=0 and execute_enable=1, held for exactly one cycle; then IDLE. execute_addr holds its value until the next start.
- Throughput with no stalls: ROM_LAT+1 cycles per byte. First dn_wr is visible after edge S+ROM_LAT, where S is the start edge.
- Address arithmetic is modulo 2^ADDR_W; e.g. rd_addr FFFF→0000 wraps silently.
- start while busy is ignored. start and abort together in IDLE: abort wins, no copy.
- abort in FETCH or WRITE: next edge gives dn_wr=0, dn_go=0, state IDLE, no execute_enable. A write accepted on that same edge still counts as written.
- dn_wait is ignored when dn_wr=0.

Test Plan:
- ROM_LAT=1, src=0, dst=0, len=4, ROM[i]=i+0x10, dn_wait=0, start at edge S → dn_wr at (addr,data) (0,10),(1,11),(2,12),(3,13) on edges S+2, S+4, S+6, S+8; execute_enable high only after S+8; dn_go falls on the same edge.
- ROM_LAT=2, src=0x0100, dst=0x8000, len=3 → writes to 8000..8002 with ROM[0100..0102]; 3 cycles per byte; execute_addr = exec_addr = 0x0000.
- dn_wait held high for 5 cycles during byte 1 of a len=3 copy → dn_wr/addr/data stable throughout; exactly 3 writes total; completion delayed by 5 cycles.
- src=0xFFFE, dst=0xFFFF, len=3 → reads FFFE, FFFF, 0000; writes FFFF, 0000, 0001.
- len=0 start → no dn_wr; execute_enable pulses one cycle after the start edge. AUTO_START=1 → copy begins one edge after reset falls.
- abort after byte 1 → dn_go low next edge, no execute pulse. Reset asserted mid-write → outputs 0 immediately. A fresh start then completes normally.
